alu_cdb_port: RTL and testbench

- Back end of the reservation-station dispatch interface: accepts one dispatched op per cycle (alu_ena bundle), computes the RV32I integer result, and broadcasts it to the ROB and reservation stations over the ALU CDB lane.
- Results are buffered in a small FIFO because the CDB arbiter may withhold the lane (load unit has priority).
- Provides backpressure to the reservation station and is flushed on rollback.

---
 rtl/alu_cdb_port.sv | 112 +++++++++++
 tb/tb_alu_cdb_port.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_cdb_port.sv
// RV32I integer ALU feeding a small result FIFO that drains onto the ALU CDB lane.
// The queue absorbs cycles where the arbiter withholds the lane and is flushed on rollback.
module alu_cdb_port #(
    parameter int QUE_BIT = 2,
    parameter int ROB_BIT = 4,
    parameter int OPT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rb,
    input  logic               alu_ena,
    input  logic [OPT_W-1:0]   alu_opt,
    input  logic [31:0]        alu_val1,
    input  logic [31:0]        alu_val2,
    input  logic [31:0]        alu_imm,
    input  logic [ROB_BIT-1:0] alu_rob_idx,
    input  logic               cdb_grant,
    output logic               alu_full,
    output logic               cdb_alu_valid,
    output logic [ROB_BIT-1:0] cdb_alu_src,
    output logic [31:0]        cdb_alu_val,
    output logic               alu_ovf
);
    localparam int QUE_SIZE = 1 << QUE_BIT;

    logic [ROB_BIT-1:0] r_q_src [QUE_SIZE];
    logic [31:0]        r_q_val [QUE_SIZE];
    logic [QUE_BIT-1:0] r_head;
    logic [QUE_BIT-1:0] r_tail;
    logic [QUE_BIT:0]   r_count;
    logic               r_ovf;

    logic [31:0] w_b;
    logic [4:0]  w_shamt;
    logic [31:0] w_result;
    logic        w_imm_form;
    logic        w_nonempty;
    logic        w_que_full;
    logic        w_deq;
    logic        w_enq;

    // Opcodes 11..19 are the immediate forms of the register ALU ops.
    assign w_imm_form = (alu_opt >= OPT_W'(11)) && (alu_opt <= OPT_W'(19));
    assign w_b        = w_imm_form ? alu_imm : alu_val2;
    assign w_shamt    = w_b[4:0];

    always_comb begin
        w_result = 32'd0;
        case (int'(alu_opt))
            1, 11:   w_result = alu_val1 + w_b;
            2:       w_result = alu_val1 - w_b;
            3, 17:   w_result = alu_val1 << w_shamt;
            4, 12:   w_result = {31'd0, $signed(alu_val1) < $signed(w_b)};
            5, 13:   w_result = {31'd0, alu_val1 < w_b};
            6, 14:   w_result = alu_val1 ^ w_b;
            7, 18:   w_result = alu_val1 >> w_shamt;
            8, 19:   w_result = $signed(alu_val1) >>> w_shamt;
            9, 15:   w_result = alu_val1 | w_b;
            10, 16:  w_result = alu_val1 & w_b;
            20:      w_result = alu_imm;
            21:      w_result = {31'd0, alu_val1 == alu_val2};
            22:      w_result = {31'd0, alu_val1 != alu_val2};
            23:      w_result = {31'd0, $signed(alu_val1) < $signed(alu_val2)};
            24:      w_result = {31'd0, $signed(alu_val1) >= $signed(alu_val2)};
            25:      w_result = {31'd0, alu_val1 < alu_val2};
            26:      w_result = {31'd0, alu_val1 >= alu_val2};
            default: w_result = 32'd0;
        endcase
    end

    assign w_nonempty = (r_count != '0);
    assign w_que_full = (r_count == (QUE_BIT+1)'(QUE_SIZE));
    assign w_deq      = w_nonempty && cdb_grant && rdy && !rb;
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    assign w_enq      = alu_ena && !rb && (!w_que_full || w_deq);

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_src[r_tail] <= alu_rob_idx;
            r_q_val[r_tail] <= w_result;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (rb) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) r_tail <= r_tail + 1'b1;
            if (w_deq) r_head <= r_head + 1'b1;
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (alu_ena && w_que_full && !w_deq) r_ovf <= 1'b1;
        end
    end

    assign cdb_alu_valid = w_nonempty;
    assign cdb_alu_src   = w_nonempty ? r_q_src[r_head] : '0;
    assign cdb_alu_val   = w_nonempty ? r_q_val[r_head] : 32'd0;
    assign alu_full      = (r_count >= (QUE_BIT+1)'(QUE_SIZE - 2));
    assign alu_ovf       = r_ovf;
endmodule

// File: tb/tb_alu_cdb_port.sv
// Directed bench for alu_cdb_port: opcode results, queue fill/drain, overflow, rollback, stall, reset.
module tb_alu_cdb_port;
    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        rb;
    logic        alu_ena;
    logic [5:0]  alu_opt;
    logic [31:0] alu_val1;
    logic [31:0] alu_val2;
    logic [31:0] alu_imm;
    logic [3:0]  alu_rob_idx;
    logic        cdb_grant;
    logic        alu_full;
    logic        cdb_alu_valid;
    logic [3:0]  cdb_alu_src;
    logic [31:0] cdb_alu_val;
    logic        alu_ovf;

    int checks   = 0;
    int failures = 0;

    alu_cdb_port #(.QUE_BIT(2), .ROB_BIT(4), .OPT_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rb(rb),
        .alu_ena(alu_ena), .alu_opt(alu_opt), .alu_val1(alu_val1),
        .alu_val2(alu_val2), .alu_imm(alu_imm), .alu_rob_idx(alu_rob_idx),
        .cdb_grant(cdb_grant), .alu_full(alu_full),
        .cdb_alu_valid(cdb_alu_valid), .cdb_alu_src(cdb_alu_src),
        .cdb_alu_val(cdb_alu_val), .alu_ovf(alu_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Queue an ADD of tag+0 so the broadcast value equals the tag.
    task automatic push(input int tag);
        alu_ena = 1'b1; alu_opt = 6'd1;
        alu_val1 = 32'(tag); alu_val2 = 32'd0; alu_rob_idx = 4'(tag);
        tick();
        alu_ena = 1'b0;
    endtask

    // One op with the lane granted: result visible one cycle later, gone the next.
    task automatic op(input string name, input int opt, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, input logic [31:0] exp);
        cdb_grant = 1'b1;
        alu_ena = 1'b1; alu_opt = 6'(opt);
        alu_val1 = a; alu_val2 = b; alu_imm = imm; alu_rob_idx = 4'd6;
        tick();
        alu_ena = 1'b0;
        check({name, "_val"}, cdb_alu_val, exp);
        check({name, "_src"}, {28'd0, cdb_alu_src}, 32'd6);
        tick();
        check({name, "_drained"}, {31'd0, cdb_alu_valid}, 32'd0);
    endtask

    task automatic expect_head(input string name, input int tag);
        check({name, "_valid"}, {31'd0, cdb_alu_valid}, 32'd1);
        check({name, "_src"}, {28'd0, cdb_alu_src}, 32'(tag));
        check({name, "_val"}, cdb_alu_val, 32'(tag));
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; rb = 1'b0; alu_ena = 1'b0; alu_opt = '0;
        alu_val1 = '0; alu_val2 = '0; alu_imm = '0; alu_rob_idx = '0; cdb_grant = 1'b0;
        #1;
        check("rst_valid", {31'd0, cdb_alu_valid}, 32'd0);
        check("rst_src",   {28'd0, cdb_alu_src}, 32'd0);
        check("rst_val",   cdb_alu_val, 32'd0);
        check("rst_full",  {31'd0, alu_full}, 32'd0);
        check("rst_ovf",   {31'd0, alu_ovf}, 32'd0);
        tick(); tick();
        rst = 1'b1;

        // Basic ADD latency and drain
        cdb_grant = 1'b1;
        alu_ena = 1'b1; alu_opt = 6'd1; alu_val1 = 32'd5; alu_val2 = 32'd7; alu_rob_idx = 4'd3;
        tick();
        alu_ena = 1'b0;
        check("add_valid", {31'd0, cdb_alu_valid}, 32'd1);
        check("add_src", {28'd0, cdb_alu_src}, 32'd3);
        check("add_val", cdb_alu_val, 32'd12);
        tick();
        check("add_after", {31'd0, cdb_alu_valid}, 32'd0);

        op("sra",   8,  32'h8000_0000, 32'h0000_0024, 32'd0,          32'hF800_0000);
        op("sltu",  5,  32'd1,         32'hFFFF_FFFF, 32'd0,          32'd1);
        op("sub",   2,  32'd3,         32'd5,         32'd0,          32'hFFFF_FFFE);
        op("slt",   4,  32'hFFFF_FFFF, 32'd1,         32'd0,          32'd1);
        op("sltu0", 5,  32'hFFFF_FFFF, 32'd1,         32'd0,          32'd0);
        op("sll",   3,  32'd1,         32'h21,        32'd0,          32'd2);
        op("addi",  11, 32'hFFFF_FFFF, 32'd99,        32'd2,          32'd1);
        op("xori",  14, 32'hF0F0_F0F0, 32'd0,         32'hFFFF_0000,  32'h0F0F_F0F0);
        op("andi",  16, 32'hFF00_FF00, 32'd0,         32'h0F0F_0F0F,  32'h0F00_0F00);
        op("srli",  18, 32'h8000_0000, 32'd0,         32'd31,         32'd1);
        op("srai",  19, 32'h8000_0000, 32'd0,         32'd31,         32'hFFFF_FFFF);
        op("lui",   20, 32'd1,         32'd2,         32'h1234_5000,  32'h1234_5000);
        op("beq",   21, 32'd7,         32'd7,         32'd0,          32'd1);
        op("bne",   22, 32'd7,         32'd7,         32'd0,          32'd0);
        op("blt",   23, 32'hFFFF_FFFF, 32'd0,         32'd0,          32'd1);
        op("bgeu",  26, 32'hFFFF_FFFF, 32'd0,         32'd0,          32'd1);
        op("op40",  40, 32'd5,         32'd5,         32'd5,          32'd0);

        // Grant withheld: fill, overflow on the 5th
        cdb_grant = 1'b0;
        push(1);
        check("fill1_full", {31'd0, alu_full}, 32'd0);
        push(2);
        check("fill2_full", {31'd0, alu_full}, 32'd1);
        push(3); push(4);
        check("fill4_ovf", {31'd0, alu_ovf}, 32'd0);
        push(5);
        check("fill5_ovf", {31'd0, alu_ovf}, 32'd1);
        expect_head("hold_head", 1);
        cdb_grant = 1'b1;
        expect_head("drain1", 1); tick();
        expect_head("drain2", 2); tick();
        expect_head("drain3", 3); tick();
        expect_head("drain4", 4); tick();
        check("drain_empty", {31'd0, cdb_alu_valid}, 32'd0);
        check("ovf_sticky", {31'd0, alu_ovf}, 32'd1);

        // Asynchronous reset clears the sticky error
        #2 rst = 1'b0;
        #1 check("rst2_ovf", {31'd0, alu_ovf}, 32'd0);
        @(negedge clk); rst = 1'b1;
        tick();

        // Full queue with simultaneous push and pop
        cdb_grant = 1'b0;
        push(1); push(2); push(3); push(4);
        cdb_grant = 1'b1;
        push(7);
        check("simul_ovf", {31'd0, alu_ovf}, 32'd0);
        expect_head("simul2", 2); tick();
        expect_head("simul3", 3); tick();
        expect_head("simul4", 4); tick();
        expect_head("simul7", 7); tick();
        check("simul_empty", {31'd0, cdb_alu_valid}, 32'd0);

        // Rollback with a dispatch in the same cycle
        cdb_grant = 1'b0;
        push(1); push(2); push(3);
        rb = 1'b1;
        push(8);
        rb = 1'b0;
        check("rb_valid", {31'd0, cdb_alu_valid}, 32'd0);
        check("rb_full", {31'd0, alu_full}, 32'd0);
        cdb_grant = 1'b1;
        push(9);
        expect_head("rb_tag9", 9);
        tick();
        check("rb_alone", {31'd0, cdb_alu_valid}, 32'd0);

        // Stall with rdy low, then async reset mid-cycle
        cdb_grant = 1'b0;
        push(10); push(11);
        cdb_grant = 1'b1; rdy = 1'b0;
        tick();
        expect_head("stall1", 10);
        tick();
        expect_head("stall2", 10);
        #3 rst = 1'b0;
        #1;
        check("arst_valid", {31'd0, cdb_alu_valid}, 32'd0);
        check("arst_src", {28'd0, cdb_alu_src}, 32'd0);
        check("arst_val", cdb_alu_val, 32'd0);
        check("arst_full", {31'd0, alu_full}, 32'd0);
        rst = 1'b1; rdy = 1'b1;
        push(12);
        expect_head("post_rst", 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
